// File: rtl/lcd_write_sequencer.sv
// ST7920 8-bit parallel write sequencer: one byte per handshake, E strobe timed with a single down-counter.
// Optional power-on init ROM sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_write_sequencer #(
  parameter int SETUP_CYCLES   = 5,
  parameter int E_HIGH_CYCLES  = 25,
  parameter int HOLD_CYCLES    = 5,
  parameter int WAIT_CYCLES    = 3600,
  parameter int CLEAR_CYCLES   = 80000,
  parameter int POWERUP_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  localparam int MAX_CYC = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT_LOAD, ST_SETUP, ST_E_HIGH, ST_HOLD, ST_WAIT, ST_IDLE
  } state_t;

  // A timed state of N cycles loads N-1 and leaves when the counter reads zero; N=0 behaves as N=1.
  function automatic logic [CNT_W-1:0] reload(input int n);
    if (n <= 1) return '0;
    return CNT_W'(n - 1);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam int INIT_LEN = 5;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h30;
      3'd1:    return 8'h30;
      3'd2:    return 8'h0C;
      3'd3:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic [2:0] init_idx_q, init_idx_d;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             cnt_zero;
  logic             long_wait;

  assign cnt_zero  = (cnt_q == '0);
  // Clear and return-home need the long execution time.
  assign long_wait = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    db_d        = db_q;
`ifdef LCD_INIT_SEQ_EN
    init_idx_d  = init_idx_q;
`endif
    case (state_q)
      ST_POWERUP: begin
`ifdef LCD_INIT_SEQ_EN
        if (cnt_zero) state_d = ST_INIT_LOAD;
        else          cnt_d   = cnt_q - 1'b1;
`else
        state_d     = ST_IDLE;
        init_done_d = 1'b1;
`endif
      end
      ST_INIT_LOAD: begin
`ifdef LCD_INIT_SEQ_EN
        rs_d       = 1'b0;
        db_d       = init_rom(init_idx_q);
        init_idx_d = init_idx_q + 3'd1;
        state_d    = ST_SETUP;
        cnt_d      = reload(SETUP_CYCLES);
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          rs_d    = cmd_rs;
          db_d    = cmd_data;
          state_d = ST_SETUP;
          cnt_d   = reload(SETUP_CYCLES);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_E_HIGH;
          cnt_d   = reload(E_HIGH_CYCLES);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_E_HIGH: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = reload(HOLD_CYCLES);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait ? reload(CLEAR_CYCLES) : reload(WAIT_CYCLES);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_idx_q < 3'(INIT_LEN)) begin
            state_d = ST_INIT_LOAD;
          end else begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
`else
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
`endif
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_POWERUP;
`ifdef LCD_INIT_SEQ_EN
      cnt_q       <= reload(POWERUP_CYCLES);
      init_idx_q  <= '0;
`else
      cnt_q       <= '0;
`endif
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef LCD_INIT_SEQ_EN
      init_idx_q  <= init_idx_d;
`endif
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign init_done = init_done_q;
  assign lcd_e     = (state_q == ST_E_HIGH);
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: random writes, expected bytes and timing queued at the handshake,
// checked by an independent E-strobe monitor. Covers LCD_INIT_SEQ_EN on or off.
module tb_lcd_write_sequencer;
  localparam int S  = 2;
  localparam int EH = 4;
  localparam int H  = 2;
  localparam int W  = 20;
  localparam int C  = 50;
  localparam int P  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  lcd_write_sequencer #(
    .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(H),
    .WAIT_CYCLES(W), .CLEAR_CYCLES(C), .POWERUP_CYCLES(P)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         hs;
    int         gap;
    bit         chk_ready;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference timing: handshake cycle plus the four phases; long wait for clear/home instructions.
  function automatic int exp_gap(input logic rs, input logic [7:0] d);
    return 1 + S + EH + H + ((!rs && (d == 8'h01 || d == 8'h02)) ? C : W);
  endfunction

  // Monitor
  bit   in_pulse = 0;
  bit   await_ready = 0;
  int   rise_cyc = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      in_pulse    = 0;
      await_ready = 0;
    end else begin
      if (lcd_e && !in_pulse) begin
        in_pulse = 1;
        rise_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_e_pulse", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("db_at_e_rise", int'(lcd_db), int'(cur.db));
          check("rs_at_e_rise", int'(lcd_rs), int'(cur.rs));
          check("rw_low", int'(lcd_rw), 0);
          check("setup_latency", cyc - cur.hs, 1 + S);
          await_ready = cur.chk_ready;
        end
      end else if (lcd_e && in_pulse) begin
        check("db_stable_e_high", int'({lcd_rs, lcd_db}), int'({cur.rs, cur.db}));
      end else if (!lcd_e && in_pulse) begin
        in_pulse = 0;
        check("e_width", cyc - rise_cyc, EH);
      end
      if (await_ready && cmd_ready) begin
        await_ready = 0;
        check("ready_return", cyc - cur.hs, cur.gap);
      end
    end
  end

  // Stimulus
  task automatic wait_ready(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit keep);
    bit ok;
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    wait_ready(200, ok);
    if (!ok) begin
      check("handshake_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{rs, d, cyc, exp_gap(rs, d), 1'b1});
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
    cmd_rs   = 1'($urandom);
    cmd_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready && sb.size() == 0 && !await_ready && !in_pulse) begin done = 1; break; end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_lcd_db", int'(lcd_db), 0);
  endtask

  // Called at #1 after the last edge that sampled reset high; that cycle is 'rel'.
  task automatic after_reset(input int rel);
    int exp_ready;
    bit ok;
`ifdef LCD_INIT_SEQ_EN
    logic [7:0] rom [5];
    int hs;
    rom = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
    hs  = rel + P;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{1'b0, rom[i], hs, exp_gap(1'b0, rom[i]), (i == 4)});
      if (i < 4) hs += exp_gap(1'b0, rom[i]);
    end
    exp_ready = hs + exp_gap(1'b0, rom[4]);
`else
    exp_ready = rel + 1;
`endif
    wait_ready(1500, ok);
    if (!ok) check("init_ready_timeout", 0, 1);
    check("ready_after_reset_cycle", cyc, exp_ready);
    check("init_done_at_ready", int'(init_done), 1);
    check("busy_at_ready", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   rel;
    bit   ok;
    logic rs;
    logic [7:0] d;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    after_reset(rel);

    send(1'b1, 8'h41, 1'b0);
    wait_idle();
    send(1'b0, 8'h01, 1'b0);
    wait_idle();
    send(1'b0, 8'h80, 1'b0);
    wait_idle();
    send(1'b0, 8'h02, 1'b0);
    wait_idle();

    // Streaming: valid held across three requests.
    send(1'b1, 8'hA5, 1'b1);
    send(1'b1, 8'h5A, 1'b1);
    send(1'b0, 8'h38, 1'b0);
    wait_idle();

    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        d  = 8'($urandom_range(1, 2));
      end else begin
        rs = 1'($urandom);
        d  = 8'($urandom);
      end
      send(rs, d, 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Quiet period: any E pulse here is unexpected.
    repeat (60) @(posedge clk);
    #1;

    // Reset while E is high.
    send(1'b1, 8'hC3, 1'b0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_e) begin ok = 1; break; end
    end
    if (!ok) check("e_rise_timeout", 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    after_reset(rel);

    send(1'b1, 8'h7E, 1'b0);
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
